// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the PLL wrapper / downstream reset consumers.
interface pll_reset_sequencer_if;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] loss_count;
    logic [7:0] retry_count;
    logic       timeout_err;

    modport master (
        input  pll_locked,
        output pll_rst, sys_rst, ready, loss_count, retry_count, timeout_err
    );

    modport slave (
        output pll_locked,
        input  pll_rst, sys_rst, ready, loss_count, retry_count, timeout_err
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, qualifies lock and releases the system reset; retries on lock timeout.
// Optional lock-loss / retry counters are built only when PLL_SEQ_LOSS_COUNT_EN is defined.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int RESET_HOLD_CYCLES   = 256,
    parameter int LOCK_TIMEOUT_CYCLES = 500000,
    parameter int CNT_W               = 20
) (
    input logic                    refclk,
    input logic                    rst,
    pll_reset_sequencer_if.master  pll
);

    localparam longint CNT_LIMIT = longint'(1) << CNT_W;

    if (PLL_RST_CYCLES < 1 || longint'(PLL_RST_CYCLES) >= CNT_LIMIT ||
        LOCK_STABLE_CYCLES < 1 || longint'(LOCK_STABLE_CYCLES) >= CNT_LIMIT ||
        RESET_HOLD_CYCLES < 1 || longint'(RESET_HOLD_CYCLES) >= CNT_LIMIT ||
        LOCK_TIMEOUT_CYCLES < 1 || longint'(LOCK_TIMEOUT_CYCLES) >= CNT_LIMIT) begin : g_bad_params
        $error("pll_reset_sequencer: cycle parameters must be >= 1 and < 2**CNT_W");
    end

    localparam logic [CNT_W-1:0] RELOAD_PLL     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELOAD_STABLE  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELOAD_HOLD    = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELOAD_TIMEOUT = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        HOLD,
        RUN
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             sync_ff1, locked_s;
    logic             retry_evt;
    logic             pll_rst_q, sys_rst_q, ready_q, timeout_err_q;

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_ff1 <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_ff1 <= pll.pll_locked;
            locked_s <= sync_ff1;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state <= PLL_RST;
            cnt   <= RELOAD_PLL;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Lock takes priority over an expiring timeout in WAIT_LOCK.
    always_comb begin
        state_next = state;
        cnt_next   = cnt - 1'b1;
        retry_evt  = 1'b0;
        case (state)
            PLL_RST: begin
                if (cnt == '0) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = RELOAD_TIMEOUT;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_next = STABLE;
                    cnt_next   = RELOAD_STABLE;
                end else if (cnt == '0) begin
                    state_next = PLL_RST;
                    cnt_next   = RELOAD_PLL;
                    retry_evt  = 1'b1;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = RELOAD_TIMEOUT;
                end else if (cnt == '0) begin
                    state_next = HOLD;
                    cnt_next   = RELOAD_HOLD;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = RELOAD_TIMEOUT;
                end else if (cnt == '0) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                cnt_next = '0;
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = RELOAD_TIMEOUT;
                end
            end
            default: begin
                state_next = PLL_RST;
                cnt_next   = RELOAD_PLL;
            end
        endcase
    end

    // Outputs are flopped from the next-state decode so they change on the same edge as the state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            pll_rst_q     <= 1'b1;
            sys_rst_q     <= 1'b1;
            ready_q       <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            pll_rst_q <= (state_next == PLL_RST);
            sys_rst_q <= (state_next != RUN);
            ready_q   <= (state_next == RUN);
            if (retry_evt) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign pll.pll_rst     = pll_rst_q;
    assign pll.sys_rst     = sys_rst_q;
    assign pll.ready       = ready_q;
    assign pll.timeout_err = timeout_err_q;

`ifdef PLL_SEQ_LOSS_COUNT_EN
    logic       loss_evt;
    logic [7:0] loss_q, retry_q;

    assign loss_evt = (state == RUN) && !locked_s;

    always_ff @(posedge refclk) begin
        if (rst) begin
            loss_q  <= 8'd0;
            retry_q <= 8'd0;
        end else begin
            if (loss_evt && loss_q != 8'hFF) begin
                loss_q <= loss_q + 8'd1;
            end
            if (retry_evt && retry_q != 8'hFF) begin
                retry_q <= retry_q + 8'd1;
            end
        end
    end

    assign pll.loss_count  = loss_q;
    assign pll.retry_count = retry_q;
`else
    assign pll.loss_count  = 8'd0;
    assign pll.retry_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small cycle parameters; edge numbers count from the
// first edge after rst falls. Count expectations follow PLL_SEQ_LOSS_COUNT_EN.
module tb_pll_reset_sequencer;

    logic refclk;
    logic rst;
    int   tests_run;
    int   fail_count;

    pll_reset_sequencer_if bus ();

    pll_reset_sequencer #(
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .RESET_HOLD_CYCLES   (4),
        .LOCK_TIMEOUT_CYCLES (32),
        .CNT_W               (20)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .pll    (bus)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    function automatic logic [7:0] countExp(input int n);
`ifdef PLL_SEQ_LOSS_COUNT_EN
        return 8'(n);
`else
        return 8'd0;
`endif
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input logic locked_v);
        rst            = rst_v;
        bus.pll_locked = locked_v;
    endtask

    task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic e_pll_rst, input logic e_sys_rst,
                               input logic e_ready, input logic [7:0] e_loss,
                               input logic [7:0] e_retry, input logic e_terr);
        checkVal({tag, ".pll_rst"}, 8'(bus.pll_rst), 8'(e_pll_rst));
        checkVal({tag, ".sys_rst"}, 8'(bus.sys_rst), 8'(e_sys_rst));
        checkVal({tag, ".ready"}, 8'(bus.ready), 8'(e_ready));
        checkVal({tag, ".loss_count"}, bus.loss_count, e_loss);
        checkVal({tag, ".retry_count"}, bus.retry_count, e_retry);
        checkVal({tag, ".timeout_err"}, 8'(bus.timeout_err), 8'(e_terr));
    endtask

    initial begin
        tests_run  = 0;
        fail_count = 0;

        // Power-up reset, then first lock 2 cycles after pll_rst falls.
        applyStimulus(1'b1, 1'b0);
        tick(1);
        checkOutput("reset", 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        tick(3);
        checkVal("pll_rst_e3", 8'(bus.pll_rst), 8'd1);
        tick(1);
        checkVal("pll_rst_e4", 8'(bus.pll_rst), 8'd0);
        tick(2);
        applyStimulus(1'b0, 1'b1);
        tick(14);
        checkVal("first_sys_rst_a14", 8'(bus.sys_rst), 8'd1);
        checkVal("first_ready_a14", 8'(bus.ready), 8'd0);
        tick(1);
        checkOutput("first_run_a15", 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0);

        // One-cycle lock drop in RUN, then automatic requalification.
        applyStimulus(1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b1);
        tick(1);
        checkVal("loss1_sys_rst_b2", 8'(bus.sys_rst), 8'd0);
        tick(1);
        checkOutput("loss1_b3", 1'b0, 1'b1, 1'b0, countExp(1), 8'd0, 1'b0);
        tick(12);
        checkVal("relock1_sys_rst_b15", 8'(bus.sys_rst), 8'd1);
        tick(1);
        checkOutput("relock1_b16", 1'b0, 1'b0, 1'b1, countExp(1), 8'd0, 1'b0);

        // Second loss so that the mid-run reset sees a count of 2.
        applyStimulus(1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b1);
        tick(2);
        checkVal("loss2_count", bus.loss_count, countExp(2));
        tick(13);
        checkOutput("relock2_b16", 1'b0, 1'b0, 1'b1, countExp(2), 8'd0, 1'b0);

        // Synchronous reset pulse while in RUN.
        applyStimulus(1'b1, 1'b0);
        tick(1);
        checkOutput("mid_reset", 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b0);

        // 5-cycle lock glitch in WAIT_LOCK restarts the timeout from E14.
        tick(4);
        checkVal("glitch_pll_rst_e4", 8'(bus.pll_rst), 8'd0);
        tick(2);
        applyStimulus(1'b0, 1'b1);
        tick(5);
        applyStimulus(1'b0, 1'b0);
        for (int e = 12; e <= 45; e++) begin
            tick(1);
            checkVal($sformatf("glitch_sys_rst_e%0d", e), 8'(bus.sys_rst), 8'd1);
            checkVal($sformatf("glitch_pll_rst_e%0d", e), 8'(bus.pll_rst), 8'd0);
        end
        checkVal("glitch_terr_e45", 8'(bus.timeout_err), 8'd0);
        checkVal("glitch_loss_e45", bus.loss_count, 8'd0);

        // Repeated timeouts: retry pulses of 4 cycles every 36 cycles.
        tick(1);
        checkOutput("retry1_e46", 1'b1, 1'b1, 1'b0, 8'd0, countExp(1), 1'b1);
        tick(3);
        checkVal("retry1_pll_rst_e49", 8'(bus.pll_rst), 8'd1);
        tick(1);
        checkVal("retry1_pll_rst_e50", 8'(bus.pll_rst), 8'd0);
        tick(31);
        checkVal("retry2_pll_rst_e81", 8'(bus.pll_rst), 8'd0);
        tick(1);
        checkVal("retry2_pll_rst_e82", 8'(bus.pll_rst), 8'd1);
        checkVal("retry2_count", bus.retry_count, countExp(2));
        tick(35);
        checkVal("retry3_pll_rst_e117", 8'(bus.pll_rst), 8'd0);
        tick(1);
        checkOutput("retry3_e118", 1'b1, 1'b1, 1'b0, 8'd0, countExp(3), 1'b1);

        // Lock during the retry pulse: release at E135, timeout_err stays set.
        applyStimulus(1'b0, 1'b1);
        tick(16);
        checkVal("after_retry_sys_rst_e134", 8'(bus.sys_rst), 8'd1);
        tick(1);
        checkOutput("after_retry_run_e135", 1'b0, 1'b0, 1'b1, 8'd0, countExp(3), 1'b1);

        // Lock arriving on the cycle the timeout expires wins over the retry.
        applyStimulus(1'b1, 1'b0);
        tick(1);
        checkOutput("reset2", 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        tick(33);
        applyStimulus(1'b0, 1'b1);
        tick(3);
        checkOutput("lock_wins_e36", 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
        tick(11);
        checkVal("lock_wins_sys_rst_e47", 8'(bus.sys_rst), 8'd1);
        tick(1);
        checkOutput("lock_wins_run_e48", 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
